key_loader: RTL and testbench

- Serial key-delivery controller: the producer side of the key-input interface on our locked netlists.
- Accepts a key as a serial bit stream, assembles it in a shadow register and validates it.
- Commits a valid key in one step to the parallel key bus that drives the locked circuit's D_* inputs.
- Counts failed loads and locks out permanently after a programmable number of failures; sits between the key-storage/serial interface and the locked combinational core.

---
 rtl/key_loader_if.sv | 25 ++
 rtl/key_loader.sv | 134 +++++++++++++
 tb/tb_key_loader.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/key_loader_if.sv
// Key-delivery interface: start/serial-bit handshake from the key store and
// the committed parallel key bus plus status flags toward the locked core.
// The slave modport is the key_loader itself; the master modport is the key source.
interface key_loader_if #(
    parameter int KEY_W = 2
);
    logic             KEY_LD;
    logic             KEY_SV;
    logic             KEY_SI;
    logic             KEY_SR;
    logic [KEY_W-1:0] D;
    logic             KEY_VLD;
    logic             KEY_ERR;
    logic             LOCKOUT;

    modport master (
        output KEY_LD, KEY_SV, KEY_SI,
        input  KEY_SR, D, KEY_VLD, KEY_ERR, LOCKOUT
    );

    modport slave (
        input  KEY_LD, KEY_SV, KEY_SI,
        output KEY_SR, D, KEY_VLD, KEY_ERR, LOCKOUT
    );
endinterface

// File: rtl/key_loader.sv
// key_loader: serial key-delivery controller for locked netlists.
// A key arrives LSB first, is assembled in a shadow register, validated and
// committed to D in a single step, so D never shows a partially shifted key.
// Optional feature macro KEY_ALLOW_CHECK_EN: enables the pairwise key check,
// the saturating fail counter and the permanent lockout. Without it every
// completed load passes, and KEY_ERR / LOCKOUT are tied low.
module key_loader #(
    parameter int KEY_W    = 2,
    parameter int MAX_FAIL = 3
) (
    input logic         CK,
    input logic         RST,
    key_loader_if.slave kif
);
    localparam int CNT_W = (KEY_W > 2) ? $clog2(KEY_W) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] CHECK = 2'd2;
    localparam logic [1:0] LOCK  = 2'd3;

    logic [1:0]       state;
    logic [CNT_W-1:0] bit_cnt;
    logic [KEY_W-1:0] shadow;
    logic [KEY_W-1:0] d_q;
    logic             vld_q;

`ifdef KEY_ALLOW_CHECK_EN
    localparam int FAIL_W = $clog2(MAX_FAIL + 1);

    logic [FAIL_W-1:0] fail_cnt;
    logic              err_q;
    logic              lockout_q;
    logic              key_ok;

    // A key is acceptable only if every bit pair (2i, 2i+1) is 00 or 11.
    always_comb begin
        key_ok = 1'b1;
        for (int i = 0; i < KEY_W / 2; i++) begin
            if (shadow[2*i] != shadow[2*i+1]) begin
                key_ok = 1'b0;
            end
        end
    end

    // Failure bookkeeping: error flag, saturating fail counter and lockout flag.
    always_ff @(posedge CK) begin
        if (RST) begin
            err_q     <= 1'b0;
            lockout_q <= 1'b0;
            fail_cnt  <= '0;
        end else if (state == CHECK) begin
            if (key_ok) begin
                err_q <= 1'b0;
            end else begin
                err_q <= 1'b1;
                if (fail_cnt != FAIL_W'(MAX_FAIL)) begin
                    fail_cnt <= fail_cnt + FAIL_W'(1);
                end
                if (fail_cnt == FAIL_W'(MAX_FAIL - 1)) begin
                    lockout_q <= 1'b1;
                end
            end
        end
    end

    assign kif.KEY_ERR = err_q;
    assign kif.LOCKOUT = lockout_q;
`else
    assign kif.KEY_ERR = 1'b0;
    assign kif.LOCKOUT = 1'b0;
`endif

    // Load sequencing: shift bits into the shadow register, then commit or reject.
    always_ff @(posedge CK) begin
        if (RST) begin
            state   <= IDLE;
            bit_cnt <= '0;
            shadow  <= '0;
            d_q     <= '0;
            vld_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (kif.KEY_LD) begin
                        state   <= SHIFT;
                        bit_cnt <= '0;
                        shadow  <= '0;
                    end
                end
                SHIFT: begin
                    if (kif.KEY_SV) begin
                        shadow[bit_cnt] <= kif.KEY_SI;
                        if (bit_cnt == CNT_W'(KEY_W - 1)) begin
                            state <= CHECK;
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end
                end
                CHECK: begin
`ifdef KEY_ALLOW_CHECK_EN
                    if (key_ok) begin
                        d_q   <= shadow;
                        vld_q <= 1'b1;
                        state <= IDLE;
                    end else if (fail_cnt == FAIL_W'(MAX_FAIL - 1)) begin
                        d_q   <= '0;
                        vld_q <= 1'b0;
                        state <= LOCK;
                    end else begin
                        state <= IDLE;
                    end
`else
                    d_q   <= shadow;
                    vld_q <= 1'b1;
                    state <= IDLE;
`endif
                end
                LOCK: begin
                    d_q   <= '0;
                    vld_q <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign kif.KEY_SR  = (state == SHIFT);
    assign kif.D       = d_q;
    assign kif.KEY_VLD = vld_q;
endmodule

// File: tb/tb_key_loader.sv
// Testbench for key_loader (KEY_W=4, MAX_FAIL=3). A reference model predicts
// the committed outputs of every load; the prediction is queued when the load
// is driven and popped when the load's CHECK cycle has completed.
// Works with or without KEY_ALLOW_CHECK_EN defined.
module tb_key_loader;
    localparam int KEY_W    = 4;
    localparam int MAX_FAIL = 3;

    typedef struct packed {
        logic [KEY_W-1:0] d;
        logic             vld;
        logic             err;
        logic             lock;
    } exp_t;

    logic CK;
    logic RST;

    key_loader_if #(.KEY_W(KEY_W)) kif ();

    key_loader #(
        .KEY_W   (KEY_W),
        .MAX_FAIL(MAX_FAIL)
    ) dut (
        .CK (CK),
        .RST(RST),
        .kif(kif)
    );

    int   errorCount = 0;
    int   checkCount = 0;
    exp_t sbQ[$];

    logic [KEY_W-1:0] mD;
    logic             mVld;
    logic             mErr;
    logic             mLock;
    int               mFail;

    // Free-running clock, 10 ns period.
    initial begin
        CK = 1'b0;
        forever #5 CK = ~CK;
    end

    // Hard time limit so the bench always terminates.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed=%0h required=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge CK);
        #1;
    endtask

    function automatic bit keyPasses(input logic [KEY_W-1:0] k);
`ifdef KEY_ALLOW_CHECK_EN
        for (int i = 0; i < KEY_W / 2; i++) begin
            if (k[2*i] != k[2*i+1]) return 1'b0;
        end
`endif
        return 1'b1;
    endfunction

    task automatic modelReset();
        mD    = '0;
        mVld  = 1'b0;
        mErr  = 1'b0;
        mLock = 1'b0;
        mFail = 0;
    endtask

    task automatic checkState(input string tag);
        checkOutput({tag, "_d"},    32'(kif.D),       32'(mD));
        checkOutput({tag, "_vld"},  32'(kif.KEY_VLD), 32'(mVld));
        checkOutput({tag, "_err"},  32'(kif.KEY_ERR), 32'(mErr));
        checkOutput({tag, "_lock"}, 32'(kif.LOCKOUT), 32'(mLock));
    endtask

    task automatic doReset();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        modelReset();
    endtask

    // One full load: KEY_LD pulse, then KEY_W bits LSB first with 'gap' idle
    // cycles before each bit. svWithLd also raises KEY_SV on the KEY_LD edge.
    task automatic applyStimulus(input string tag, input logic [KEY_W-1:0] key, input int gap, input bit svWithLd);
        exp_t       e;
        logic [KEY_W-1:0] oldD;
        bit         wasLocked;
        wasLocked = mLock;
        oldD      = mD;
        if (!mLock) begin
            if (keyPasses(key)) begin
                mD   = key;
                mVld = 1'b1;
                mErr = 1'b0;
            end else begin
                mErr = 1'b1;
                if (mFail < MAX_FAIL) mFail++;
                if (mFail == MAX_FAIL) begin
                    mLock = 1'b1;
                    mD    = '0;
                    mVld  = 1'b0;
                end
            end
        end
        e.d    = mD;
        e.vld  = mVld;
        e.err  = mErr;
        e.lock = mLock;
        sbQ.push_back(e);

        kif.KEY_LD = 1'b1;
        kif.KEY_SV = svWithLd;
        kif.KEY_SI = 1'b1;
        tick();
        kif.KEY_LD = 1'b0;
        kif.KEY_SV = 1'b0;
        checkOutput({tag, "_sr_after_ld"}, 32'(kif.KEY_SR), wasLocked ? 32'd0 : 32'd1);
        for (int i = 0; i < KEY_W; i++) begin
            repeat (gap) tick();
            kif.KEY_SV = 1'b1;
            kif.KEY_SI = key[i];
            tick();
            kif.KEY_SV = 1'b0;
        end
        checkOutput({tag, "_sr_last_bit"}, 32'(kif.KEY_SR), 32'd0);
        checkOutput({tag, "_d_last_bit"},  32'(kif.D),      32'(oldD));
        tick();
        e = sbQ.pop_front();
        checkOutput({tag, "_d"},    32'(kif.D),       32'(e.d));
        checkOutput({tag, "_vld"},  32'(kif.KEY_VLD), 32'(e.vld));
        checkOutput({tag, "_err"},  32'(kif.KEY_ERR), 32'(e.err));
        checkOutput({tag, "_lock"}, 32'(kif.LOCKOUT), 32'(e.lock));
    endtask

    initial begin
        kif.KEY_LD = 1'b0;
        kif.KEY_SV = 1'b0;
        kif.KEY_SI = 1'b0;
        RST        = 1'b0;
        tick();
        doReset();
        checkOutput("reset_sr", 32'(kif.KEY_SR), 32'd0);
        checkState("reset");

        // KEY_SV pulses without a load must not change anything.
        for (int i = 0; i < 3; i++) begin
            kif.KEY_SV = 1'b1;
            kif.KEY_SI = 1'b1;
            tick();
            kif.KEY_SV = 1'b0;
            checkOutput("idle_sv_sr", 32'(kif.KEY_SR), 32'd0);
            checkState("idle_sv");
        end

        applyStimulus("load_1111_gaps", 4'b1111, 2, 1'b0);
        applyStimulus("load_0000", 4'b0000, 0, 1'b0);
        applyStimulus("load_1001", 4'b1001, 1, 1'b0);
        applyStimulus("load_0011", 4'b0011, 0, 1'b0);
        applyStimulus("ld_sv_same_edge", 4'b0000, 0, 1'b1);

        // Reset part-way through a shift discards the partial key.
        kif.KEY_LD = 1'b1;
        tick();
        kif.KEY_LD = 1'b0;
        kif.KEY_SV = 1'b1;
        kif.KEY_SI = 1'b1;
        tick();
        kif.KEY_SV = 1'b0;
        doReset();
        checkOutput("mid_rst_sr", 32'(kif.KEY_SR), 32'd0);
        checkState("mid_rst");
        applyStimulus("after_rst_0000", 4'b0000, 0, 1'b0);

        // Repeated bad keys drive the controller into lockout when checking is enabled.
        applyStimulus("bad_1", 4'b0010, 0, 1'b0);
        applyStimulus("bad_2", 4'b0010, 1, 1'b0);
        applyStimulus("bad_3", 4'b0010, 0, 1'b0);
        applyStimulus("after_lock_1111", 4'b1111, 0, 1'b0);

        doReset();
        checkState("final_reset");
        applyStimulus("post_rst_1111", 4'b1111, 0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            applyStimulus("random", KEY_W'($urandom_range(0, (1 << KEY_W) - 1)), int'($urandom_range(0, 2)), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end
endmodule
